fetch_steer: RTL and testbench

- Consumer and controller for the instruction fetch stage of the 8-bit-PC, 16-bit-instruction pipelined core.
- Holds the IF/ID pipeline register and decodes control-flow instructions in ID.
- Drives the fetch stage's load_pc, one-hot branch_sel, pc_branch and pc_rd.
- Handles reset sequencing, stalls, flag waits, branch squash and halt.

---
 rtl/fetch_steer_if.sv | 21 ++
 rtl/fetch_steer.sv | 157 +++++++++++++++
 tb/tb_fetch_steer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_steer_if.sv
// Fetch-stage bus between the PC/fetch unit (master) and fetch_steer (slave).
interface fetch_steer_if #(
  parameter int unsigned PC_W = 8
) ();
  logic [PC_W-1:0] pc1_if;
  logic [15:0]     instr_if;
  logic            load_pc;
  logic [3:0]      branch_sel;
  logic [PC_W-1:0] pc_branch;
  logic [PC_W-1:0] pc_rd;

  modport master (
    output pc1_if, instr_if,
    input  load_pc, branch_sel, pc_branch, pc_rd
  );

  modport slave (
    input  pc1_if, instr_if,
    output load_pc, branch_sel, pc_branch, pc_rd
  );
endinterface

// File: rtl/fetch_steer.sv
// IF/ID register and control-flow steering for the 8-bit-PC core's fetch stage.
// Optional FETCH_STEER_STATS_EN adds saturating taken/stall counters.
module fetch_steer #(
  parameter int unsigned PC_W = 8,
  parameter logic [15:0] NOP  = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_steer_if.slave    fetch,
  input  logic            stall_in,
  input  logic            flags_valid,
  input  logic            flag_z,
  input  logic            flag_n,
  input  logic            flag_v,
  input  logic [PC_W-1:0] rd_val,
  output logic [15:0]     instr_id,
  output logic [PC_W-1:0] pc1_id,
  output logic            valid_id,
`ifdef FETCH_STEER_STATS_EN
  output logic [15:0]     taken_cnt,
  output logic [15:0]     stall_cnt,
`endif
  output logic            halted
);

  typedef enum logic [1:0] {StInit, StRun, StWaitFlags, StHalt} state_e;

  state_e          state_q, state_d;
  logic [15:0]     instr_id_q;
  logic [PC_W-1:0] pc1_id_q;
  logic            valid_id_q;

  logic [2:0]      op, cond;
  logic [7:0]      imm8;
  logic            is_br, is_jr, is_halt, cond_true;
  logic            load_pc_c, id_capture, id_squash, redirect;
  logic [3:0]      branch_sel_c;

  assign op   = instr_id_q[15:13];
  assign cond = instr_id_q[10:8];
  assign imm8 = instr_id_q[7:0];

  logic unused_bits;
  assign unused_bits = ^instr_id_q[12:11];

  assign is_br   = valid_id_q && (op == 3'b001);
  assign is_jr   = valid_id_q && (op == 3'b010);
  assign is_halt = valid_id_q && (op == 3'b111);

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = flag_z;
      3'b010:  cond_true = !flag_z;
      3'b011:  cond_true = flag_n ^ flag_v;
      3'b100:  cond_true = flag_z | (flag_n ^ flag_v);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    load_pc_c    = 1'b0;
    branch_sel_c = 4'b0010;
    id_capture   = 1'b0;
    id_squash    = 1'b0;
    redirect     = 1'b0;
    unique case (state_q)
      StInit: begin
        load_pc_c    = 1'b1;
        branch_sel_c = 4'b0001;
        id_squash    = 1'b1;
        state_d      = StRun;
      end
      // The branch stays in ID while waiting, so the wait state re-runs the same decode.
      StRun, StWaitFlags: begin
        if (!stall_in) begin
          if (is_halt) begin
            state_d    = StHalt;
            load_pc_c  = 1'b1;
            id_capture = 1'b1;
          end else if (is_br && (cond != 3'b000) && !flags_valid) begin
            state_d = StWaitFlags;
          end else begin
            state_d   = StRun;
            load_pc_c = 1'b1;
            if (is_br && cond_true) begin
              branch_sel_c = 4'b0100;
              id_squash    = 1'b1;
              redirect     = 1'b1;
            end else if (is_jr) begin
              branch_sel_c = 4'b1000;
              id_squash    = 1'b1;
              redirect     = 1'b1;
            end else begin
              id_capture = 1'b1;
            end
          end
        end
      end
      StHalt: ;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      instr_id_q <= NOP;
      pc1_id_q   <= '0;
      valid_id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (id_squash) begin
        instr_id_q <= NOP;
        valid_id_q <= 1'b0;
      end else if (id_capture) begin
        instr_id_q <= fetch.instr_if;
        pc1_id_q   <= fetch.pc1_if;
        valid_id_q <= 1'b1;
      end
    end
  end

`ifdef FETCH_STEER_STATS_EN
  logic [15:0] taken_cnt_q, stall_cnt_q;
  logic        stall_cycle;

  assign stall_cycle = ((state_q == StRun) || (state_q == StWaitFlags)) && !load_pc_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (redirect && (taken_cnt_q != 16'hFFFF)) taken_cnt_q <= taken_cnt_q + 16'd1;
      if (stall_cycle && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  // load_pc is gated so the fetch unit sees it low for the whole reset assertion.
  assign fetch.load_pc    = load_pc_c & rst_n;
  assign fetch.branch_sel = branch_sel_c;
  assign fetch.pc_branch  = pc1_id_q + PC_W'($signed(imm8));
  assign fetch.pc_rd      = rd_val;

  assign instr_id = instr_id_q;
  assign pc1_id   = pc1_id_q;
  assign valid_id = valid_id_q;
  assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_steer.sv
// Directed self-checking bench for fetch_steer.
module tb_fetch_steer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_in, flags_valid, flag_z, flag_n, flag_v;
  logic [7:0] rd_val;
  logic [15:0] instr_id;
  logic [7:0] pc1_id;
  logic       valid_id, halted;
`ifdef FETCH_STEER_STATS_EN
  logic [15:0] taken_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_steer_if #(.PC_W(8)) fbus ();

  fetch_steer #(.PC_W(8), .NOP(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch       (fbus),
    .stall_in    (stall_in),
    .flags_valid (flags_valid),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_v      (flag_v),
    .rd_val      (rd_val),
    .instr_id    (instr_id),
    .pc1_id      (pc1_id),
    .valid_id    (valid_id),
`ifdef FETCH_STEER_STATS_EN
    .taken_cnt   (taken_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present instr/pc1 in IF for one edge so it lands in ID, then show a wrong-path op.
  task automatic load_id(input logic [15:0] instr, input logic [7:0] pc1);
    fbus.instr_if = instr;
    fbus.pc1_if   = pc1;
    tick();
    fbus.instr_if = 16'h1000;
    fbus.pc1_if   = 8'(pc1 + 8'd1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (fbus.load_pc !== 1'b0) begin bad++; $display("FAIL rst_load_pc got %b want 0", fbus.load_pc); end
    total++; if (fbus.branch_sel !== 4'b0001) begin bad++; $display("FAIL rst_sel got %b want 0001", fbus.branch_sel); end
    total++; if (instr_id !== 16'h0000) begin bad++; $display("FAIL rst_instr got %h want 0000", instr_id); end
    total++; if (pc1_id !== 8'h00) begin bad++; $display("FAIL rst_pc1 got %h want 00", pc1_id); end
    total++; if (valid_id !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", valid_id); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got %b want 0", halted); end
`ifdef FETCH_STEER_STATS_EN
    total++; if (taken_cnt !== 16'h0) begin bad++; $display("FAIL rst_taken got %h want 0", taken_cnt); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL rst_stall got %h want 0", stall_cnt); end
`endif
    rst_n = 1'b1;
    #1;
    total++; if (fbus.load_pc !== 1'b1) begin bad++; $display("FAIL init_load_pc got %b want 1", fbus.load_pc); end
    total++; if (fbus.branch_sel !== 4'b0001) begin bad++; $display("FAIL init_sel got %b want 0001", fbus.branch_sel); end
    total++; if (valid_id !== 1'b0) begin bad++; $display("FAIL init_valid got %b want 0", valid_id); end
    tick();
    fbus.instr_if = 16'h0123;
    fbus.pc1_if   = 8'h01;
    @(negedge clk);
    total++; if (fbus.branch_sel !== 4'b0010) begin bad++; $display("FAIL run1_sel got %b want 0010", fbus.branch_sel); end
    total++; if (fbus.load_pc !== 1'b1) begin bad++; $display("FAIL run1_load got %b want 1", fbus.load_pc); end
    total++; if (valid_id !== 1'b0) begin bad++; $display("FAIL run1_valid got %b want 0", valid_id); end
    tick();
    fbus.instr_if = 16'h1000;
    fbus.pc1_if   = 8'h02;
    @(negedge clk);
    total++; if (valid_id !== 1'b1) begin bad++; $display("FAIL run2_valid got %b want 1", valid_id); end
    total++; if (instr_id !== 16'h0123) begin bad++; $display("FAIL run2_instr got %h want 0123", instr_id); end
    total++; if (pc1_id !== 8'h01) begin bad++; $display("FAIL run2_pc1 got %h want 01", pc1_id); end
    total++; if (fbus.branch_sel !== 4'b0010) begin bad++; $display("FAIL run2_sel got %b want 0010", fbus.branch_sel); end
  endtask

  task automatic test_br_always();
    flags_valid = 1'b0;
    load_id(16'h20FE, 8'h05);
    @(negedge clk);
    total++; if (fbus.pc_branch !== 8'h03) begin bad++; $display("FAIL bra_target got %h want 03", fbus.pc_branch); end
    total++; if (fbus.branch_sel !== 4'b0100) begin bad++; $display("FAIL bra_sel got %b want 0100", fbus.branch_sel); end
    total++; if (fbus.load_pc !== 1'b1) begin bad++; $display("FAIL bra_load got %b want 1", fbus.load_pc); end
    tick();
    @(negedge clk);
    total++; if (instr_id !== 16'h0000) begin bad++; $display("FAIL bra_squash got %h want 0000", instr_id); end
    total++; if (valid_id !== 1'b0) begin bad++; $display("FAIL bra_bubble got %b want 0", valid_id); end
  endtask

  task automatic test_br_cond();
    flags_valid = 1'b1;
    flag_z = 1'b0;
    load_id(16'h2105, 8'h10);
    @(negedge clk);
    total++; if (fbus.branch_sel !== 4'b0010) begin bad++; $display("FAIL brz0_sel got %b want 0010", fbus.branch_sel); end
    tick();
    @(negedge clk);
    total++; if (instr_id !== 16'h1000 || valid_id !== 1'b1) begin
      bad++; $display("FAIL brz0_nosquash got %h/%b want 1000/1", instr_id, valid_id); end
    flag_z = 1'b1;
    load_id(16'h2105, 8'h10);
    @(negedge clk);
    total++; if (fbus.branch_sel !== 4'b0100) begin bad++; $display("FAIL brz1_sel got %b want 0100", fbus.branch_sel); end
    total++; if (fbus.pc_branch !== 8'h15) begin bad++; $display("FAIL brz1_target got %h want 15", fbus.pc_branch); end
    tick();
    @(negedge clk);
    total++; if (valid_id !== 1'b0) begin bad++; $display("FAIL brz1_bubble got %b want 0", valid_id); end
  endtask

  task automatic test_flag_wait();
    flags_valid = 1'b0;
    flag_z = 1'b1;
    load_id(16'h2105, 8'h20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (fbus.load_pc !== 1'b0 || fbus.branch_sel !== 4'b0010) begin
        bad++; $display("FAIL wait%0d_hold got %b/%b want 0/0010", i, fbus.load_pc, fbus.branch_sel); end
      total++; if (instr_id !== 16'h2105) begin bad++; $display("FAIL wait%0d_instr got %h want 2105", i, instr_id); end
      tick();
    end
    flags_valid = 1'b1;
    @(negedge clk);
    total++; if (fbus.branch_sel !== 4'b0100 || fbus.load_pc !== 1'b1) begin
      bad++; $display("FAIL wait_resolve got %b/%b want 0100/1", fbus.branch_sel, fbus.load_pc); end
    total++; if (fbus.pc_branch !== 8'h25) begin bad++; $display("FAIL wait_target got %h want 25", fbus.pc_branch); end
    tick();
    @(negedge clk);
    total++; if (valid_id !== 1'b0) begin bad++; $display("FAIL wait_bubble got %b want 0", valid_id); end
  endtask

  task automatic test_stall();
    load_id(16'h20FE, 8'h40);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (fbus.load_pc !== 1'b0 || fbus.branch_sel !== 4'b0010) begin
        bad++; $display("FAIL stall%0d_hold got %b/%b want 0/0010", i, fbus.load_pc, fbus.branch_sel); end
      total++; if (instr_id !== 16'h20FE || valid_id !== 1'b1) begin
        bad++; $display("FAIL stall%0d_id got %h/%b want 20fe/1", i, instr_id, valid_id); end
      tick();
    end
    stall_in = 1'b0;
    @(negedge clk);
    total++; if (fbus.branch_sel !== 4'b0100) begin bad++; $display("FAIL stall_redir got %b want 0100", fbus.branch_sel); end
    total++; if (fbus.pc_branch !== 8'h3E) begin bad++; $display("FAIL stall_target got %h want 3e", fbus.pc_branch); end
    tick();
  endtask

  task automatic test_jr();
    rd_val = 8'hA0;
    load_id(16'h4000, 8'h50);
    @(negedge clk);
    total++; if (fbus.branch_sel !== 4'b1000) begin bad++; $display("FAIL jr_sel got %b want 1000", fbus.branch_sel); end
    total++; if (fbus.pc_rd !== 8'hA0) begin bad++; $display("FAIL jr_target got %h want a0", fbus.pc_rd); end
    total++; if (fbus.load_pc !== 1'b1) begin bad++; $display("FAIL jr_load got %b want 1", fbus.load_pc); end
    tick();
    @(negedge clk);
    total++; if (valid_id !== 1'b0) begin bad++; $display("FAIL jr_bubble got %b want 0", valid_id); end
  endtask

  typedef struct packed {
    logic [15:0] instr;
    logic [7:0]  pc1;
    logic        z, n, v;
    logic [3:0]  sel;
    logic [7:0]  tgt;
  } vec_t;

  task automatic test_cond_table();
    vec_t vecs [8];
    vecs = '{
      '{16'h2002, 8'hFF, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h01},  // wraps past FF
      '{16'h2302, 8'h10, 1'b0, 1'b1, 1'b0, 4'b0100, 8'h12},
      '{16'h2302, 8'h10, 1'b0, 1'b1, 1'b1, 4'b0010, 8'h12},
      '{16'h2402, 8'h10, 1'b0, 1'b1, 1'b1, 4'b0010, 8'h12},
      '{16'h2402, 8'h10, 1'b1, 1'b0, 1'b0, 4'b0100, 8'h12},
      '{16'h2502, 8'h10, 1'b1, 1'b1, 1'b0, 4'b0010, 8'h12},
      '{16'h2780, 8'h10, 1'b1, 1'b1, 1'b0, 4'b0010, 8'h90},
      '{16'h2280, 8'h05, 1'b0, 1'b0, 1'b0, 4'b0100, 8'h85}
    };
    flags_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      flag_z = vecs[i].z;
      flag_n = vecs[i].n;
      flag_v = vecs[i].v;
      load_id(vecs[i].instr, vecs[i].pc1);
      @(negedge clk);
      total++; if (fbus.branch_sel !== vecs[i].sel) begin
        bad++; $display("FAIL cond%0d_sel got %b want %b", i, fbus.branch_sel, vecs[i].sel); end
      total++; if (fbus.pc_branch !== vecs[i].tgt) begin
        bad++; $display("FAIL cond%0d_target got %h want %h", i, fbus.pc_branch, vecs[i].tgt); end
      tick();
    end
  endtask

  task automatic test_halt();
    load_id(16'hE000, 8'h60);
    @(negedge clk);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got %b want 0", halted); end
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (halted !== 1'b1 || fbus.load_pc !== 1'b0) begin
        bad++; $display("FAIL halt%0d got %b/%b want 1/0", i, halted, fbus.load_pc); end
      total++; if (fbus.branch_sel !== 4'b0010) begin
        bad++; $display("FAIL halt%0d_sel got %b want 0010", i, fbus.branch_sel); end
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (halted !== 1'b0 || fbus.load_pc !== 1'b0) begin
      bad++; $display("FAIL halt_rst got %b/%b want 0/0", halted, fbus.load_pc); end
    total++; if (fbus.branch_sel !== 4'b0001 || valid_id !== 1'b0 || instr_id !== 16'h0000) begin
      bad++; $display("FAIL halt_rst_id got %b/%b/%h want 0001/0/0000", fbus.branch_sel, valid_id, instr_id); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (fbus.load_pc !== 1'b1 || fbus.branch_sel !== 4'b0001) begin
      bad++; $display("FAIL rerun_init got %b/%b want 1/0001", fbus.load_pc, fbus.branch_sel); end
    tick();
    @(negedge clk);
    total++; if (fbus.branch_sel !== 4'b0010 || halted !== 1'b0) begin
      bad++; $display("FAIL rerun_run got %b/%b want 0010/0", fbus.branch_sel, halted); end
  endtask

  initial begin
    rst_n         = 1'b0;
    stall_in      = 1'b0;
    flags_valid   = 1'b0;
    flag_z        = 1'b0;
    flag_n        = 1'b0;
    flag_v        = 1'b0;
    rd_val        = 8'h00;
    fbus.instr_if = 16'h0000;
    fbus.pc1_if   = 8'h00;
    test_reset();
    test_br_always();
    test_br_cond();
    test_flag_wait();
    test_stall();
    test_jr();
    test_cond_table();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
